// File: rtl/l1_cache_pkg.sv
// Shared types and address/byte helpers for the direct-mapped L1 cache.
package cache_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } cache_state_t;

  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int unsigned idx_w);
    return addr >> (idx_w + 2);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Valid/tag/data storage: combinational lookup, synchronous fill and byte merge.
import cache_types::*;

module cache_array #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic [31:0]      rdata,
  input  logic             fill_en,
  input  logic [31:0]      fill_data,
  input  logic             merge_en,
  input  logic [3:0]       merge_be,
  input  logic [31:0]      merge_wdata
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];
  logic [31:0]          data_d [NUM_LINES];

  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign rdata = data_q[idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = tag;
      data_d[idx]  = fill_data;
    end else if (merge_en) begin
      data_d[idx] = merge_bytes(data_q[idx], merge_wdata, merge_be);
    end
  end

  // Only the valid bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-through, no-write-allocate L1 cache with one outstanding request.
//   state | meaning
//   IDLE  | waiting for a core request; read hits answered from the array
//   FETCH | pmem_read held until pmem_resp, then line filled
//   WRITE | pmem_write held until pmem_resp, then hit line merged
//   RESP  | one-cycle mem_resp pulse to the core
import cache_types::*;

module l1_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  cache_state_t state_q, state_d;
  logic         mem_resp_q, mem_resp_d;
  logic [31:0]  mem_rdata_q, mem_rdata_d;
  logic         pmem_read_q, pmem_read_d;
  logic         pmem_write_q, pmem_write_d;
  logic [3:0]   pmem_be_q, pmem_be_d;
  logic [31:0]  pmem_addr_q, pmem_addr_d;
  logic [31:0]  pmem_wdata_q, pmem_wdata_d;

  logic [31:0]      lookup_addr;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [31:0]      lk_rdata;
  logic             fill_en, merge_en;

  // The pmem address register doubles as the latched request address.
  assign lookup_addr = (state_q == IDLE) ? mem_address : pmem_addr_q;
  assign lk_idx      = IDX_W'(idx_of(lookup_addr, IDX_W));
  assign lk_tag      = TAG_W'(tag_of(lookup_addr, IDX_W));

  cache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx         (lk_idx),
    .tag         (lk_tag),
    .hit         (lk_hit),
    .rdata       (lk_rdata),
    .fill_en     (fill_en),
    .fill_data   (pmem_rdata),
    .merge_en    (merge_en),
    .merge_be    (pmem_be_q),
    .merge_wdata (pmem_wdata_q)
  );

  always_comb begin
    state_d      = state_q;
    mem_resp_d   = mem_resp_q;
    mem_rdata_d  = mem_rdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_be_d    = pmem_be_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;
    fill_en      = 1'b0;
    merge_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          pmem_addr_d  = {mem_address[31:2], 2'b00};
          pmem_wdata_d = mem_wdata;
          pmem_be_d    = mem_byte_enable;
          pmem_write_d = 1'b1;
          state_d      = WRITE;
        end else if (mem_read) begin
          pmem_addr_d = {mem_address[31:2], 2'b00};
          if (lk_hit) begin
            mem_rdata_d = lk_rdata;
            mem_resp_d  = 1'b1;
            state_d     = RESP;
          end else begin
            pmem_read_d = 1'b1;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          fill_en     = 1'b1;
          mem_rdata_d = pmem_rdata;
          pmem_read_d = 1'b0;
          mem_resp_d  = 1'b1;
          state_d     = RESP;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          merge_en     = lk_hit;
          pmem_write_d = 1'b0;
          mem_resp_d   = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        mem_resp_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_resp_q   <= 1'b0;
      mem_rdata_q  <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_be_q    <= '0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_resp_q   <= mem_resp_d;
      mem_rdata_q  <= mem_rdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_be_q    <= pmem_be_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
    end
  end

  assign mem_resp         = mem_resp_q;
  assign mem_rdata        = mem_rdata_q;
  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_byte_enable = pmem_be_q;
  assign pmem_address     = pmem_addr_q;
  assign pmem_wdata       = pmem_wdata_q;

endmodule

// File: tb/tb_l1_cache.sv
// Directed vector bench for l1_cache with a bench-driven physical memory responder.
module tb_l1_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_address = '0, mem_wdata = '0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        pmem_read, pmem_write;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_address, pmem_wdata;
  logic        pmem_resp = 1'b0;
  logic [31:0] pmem_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l1_cache #(.NUM_LINES(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_resp         (mem_resp),
    .mem_rdata        (mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_resp        (pmem_resp),
    .pmem_rdata       (pmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] prd;
    logic        exp_pmem;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge with the FSM back in IDLE.
  task automatic run_txn(input vec_t v, input int n);
    int  cycles = 0;
    int  wait_cnt = 0;
    bit  got = 0;
    bit  saw = 0;
    mem_read        = v.rd;
    mem_write       = v.wr;
    mem_address     = v.addr;
    mem_byte_enable = v.be;
    mem_wdata       = v.wdata;
    while (!got && cycles < 60) begin
      @(negedge clk);
      cycles++;
      pmem_resp = 1'b0;
      if (mem_resp) begin
        got = 1;
      end else if (pmem_read || pmem_write) begin
        if (!saw) begin
          saw = 1;
          check($sformatf("v%0d pmem_address", n), pmem_address, {v.addr[31:2], 2'b00});
          check($sformatf("v%0d pmem_write", n), {31'd0, pmem_write}, {31'd0, v.wr});
          check($sformatf("v%0d pmem_read", n), {31'd0, pmem_read}, {31'd0, ~v.wr});
          if (v.wr) begin
            check($sformatf("v%0d pmem_be", n), {28'd0, pmem_byte_enable}, {28'd0, v.be});
            check($sformatf("v%0d pmem_wdata", n), pmem_wdata, v.wdata);
          end
          wait_cnt = v.lat;
        end
        if (wait_cnt == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = v.prd;
        end else begin
          wait_cnt--;
        end
      end
    end
    check($sformatf("v%0d mem_resp seen", n), {31'd0, got}, 32'd1);
    check($sformatf("v%0d pmem access", n), {31'd0, saw}, {31'd0, v.exp_pmem});
    check($sformatf("v%0d resp latency", n), cycles, v.exp_pmem ? v.lat + 2 : 1);
    check($sformatf("v%0d mem_rdata", n), mem_rdata, v.exp_rdata);
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d mem_resp one cycle", n), {31'd0, mem_resp}, 32'd0);
  endtask

  initial begin
    bit stray;
    vecs[0]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        0, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h100, 4'h3, 32'h0000CAFE, 1, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        0, 32'h0,        1'b0, 32'hDEADCAFE};
    vecs[4]  = '{1'b1, 1'b0, 32'h120, 4'h0, 32'h0,        0, 32'h12345678, 1'b1, 32'h12345678};
    vecs[5]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        2, 32'hDEADCAFE, 1'b1, 32'hDEADCAFE};
    vecs[6]  = '{1'b0, 1'b1, 32'h208, 4'hF, 32'hA5A5A5A5, 0, 32'h0,        1'b1, 32'hDEADCAFE};
    vecs[7]  = '{1'b1, 1'b0, 32'h208, 4'h0, 32'h0,        1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF, 0, 32'h0,        1'b1, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        0, 32'h0,        1'b0, 32'hDEADCAFE};
    vecs[10] = '{1'b0, 1'b1, 32'h100, 4'hC, 32'h11223344, 2, 32'h0,        1'b1, 32'hDEADCAFE};
    vecs[11] = '{1'b1, 1'b0, 32'h103, 4'h0, 32'h0,        0, 32'h0,        1'b0, 32'h1122CAFE};
    vecs[12] = '{1'b1, 1'b1, 32'h100, 4'h1, 32'h000000EE, 1, 32'h0,        1'b1, 32'h1122CAFE};
    vecs[13] = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        0, 32'h0,        1'b0, 32'h1122CAEE};

    #1;
    check("reset mem_resp",   {31'd0, mem_resp},   32'd0);
    check("reset mem_rdata",  mem_rdata,           32'd0);
    check("reset pmem_read",  {31'd0, pmem_read},  32'd0);
    check("reset pmem_write", {31'd0, pmem_write}, 32'd0);
    check("reset pmem_be",    {28'd0, pmem_byte_enable}, 32'd0);
    check("reset pmem_addr",  pmem_address,        32'd0);
    check("reset pmem_wdata", pmem_wdata,          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Abandon a fetch with reset, then deliver a stale pmem_resp.
    mem_read    = 1'b1;
    mem_address = 32'h300;
    @(negedge clk);
    check("abort pmem_read before reset", {31'd0, pmem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort pmem_read drops", {31'd0, pmem_read}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hBAD0BAD0;
    stray = 0;
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (4) begin
      if (mem_resp || pmem_read || pmem_write) stray = 1;
      @(negedge clk);
    end
    check("abort no stray activity", {31'd0, stray}, 32'd0);
    check("abort mem_rdata cleared", mem_rdata, 32'd0);
    run_txn('{1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1, 32'h1122CAEE, 1'b1, 32'h1122CAEE}, 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-through, no-write-allocate, one-word-per-line cache between the multicycle RV32I core's memory port and physical memory. Accepts the core's mem_read/mem_write word requests, serves read hits from a local array, and forwards read misses and every write to physical memory through a second request/response port of the same shape. Holds at most one outstanding transaction.

## Interface
- NUM_LINES, 8, number of lines; power of two, at least 2. IDX_W = log2(NUM_LINES).

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  core read request; held until mem_resp.
- mem_write  in  1  core write request; held until mem_resp.
- mem_byte_enable  in  4  write byte lanes; bit i covers mem_wdata[8i+7:8i].
- mem_address  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_resp  out  1  one-cycle completion pulse to the core.
- mem_rdata  out  32  read data; valid while mem_resp=1.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_byte_enable  out  4  physical write byte lanes.
- pmem_address  out  32  word-aligned physical address, bits [1:0]=0.
- pmem_wdata  out  32  physical write data.
- pmem_resp  in  1  physical completion pulse.
- pmem_rdata  in  32  physical read data; valid with pmem_resp.

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
- States: IDLE, FETCH, WRITE, RESP.
- IDLE: if mem_write, latch address/wdata/byte_enable and go to WRITE; else if mem_read, latch address; on hit (valid[index] and tag match) latch line data into mem_rdata and go to RESP, on miss go to FETCH. mem_write wins when both are asserted.
- FETCH: pmem_read=1 with the latched word address, held until pmem_resp. On pmem_resp, write valid=1, tag, data=pmem_rdata into the line, set mem_rdata=pmem_rdata, and go to RESP.
- WRITE: pmem_write=1 with the latched address, wdata, and byte_enable, held until pmem_resp. On pmem_resp, if the line hits, merge the enabled bytes into line data; a miss leaves the array unchanged (no allocate). Then go to RESP.
- byte_enable=4'b0000 write: still forwarded to memory; the line is unchanged.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. mem_rdata holds its value until the next read completes.
- The core deasserts or changes its request in the cycle after mem_resp. IDLE does not accept a request during the RESP cycle.
- pmem_resp while in IDLE or RESP is ignored.

## Timing
- Reset: state=IDLE; all valid bits=0; mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_byte_enable=0, pmem_address=0, pmem_wdata=0.
- Reset asserted mid-FETCH or mid-WRITE: strobes drop immediately, the transaction is abandoned, and a pmem_resp arriving later is ignored.
- All outputs are registered (state-decoded); none combinational from inputs.
- Read hit: request seen in cycle N, mem_resp in cycle N+1.
- Read miss / write: pmem strobe from cycle N+1; pmem_resp in cycle M; mem_resp in cycle M+1.
- A read issued in the cycle after a write completes observes the merged data.

## Structure
- Package cache_types: enum cache_state_t {IDLE, FETCH, WRITE, RESP}; helper functions idx_of()/tag_of() parameterised by IDX_W.
- Sub-module cache_array: valid/tag/data storage with asynchronous valid clear, combinational lookup (hit, rdata), synchronous fill port, and byte-enable merge port.
- The top level holds the FSM, latch registers, and output registers.

## Test plan
- Cold read of 0x100, pmem_resp after 3 cycles with 0xDEADBEEF -> one pmem_read at 0x100; mem_rdata=0xDEADBEEF with mem_resp 1 cycle later.
- Re-read 0x100 -> mem_resp in the next cycle with 0xDEADBEEF; pmem_read never asserted.
- Write 0x100, be=4'b0011, wdata=0x0000CAFE, then read 0x100 -> pmem_write with be=0011; the read hits and returns 0xDEADCAFE.
- With NUM_LINES=8, read 0x100 then 0x120 (same index, different tag), then 0x100 -> all three miss; each issues pmem_read.
- Write to uncached 0x200, then read 0x200 -> write goes to pmem, no allocate; the read misses.
- Drop rst_n during FETCH, then pulse pmem_resp -> strobe falls at once; no mem_resp; a subsequent read of 0x100 misses.
